// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus: opcode decode, DDRAM
// geometry, FSM encoding and address-counter helpers.
package lcd_pkg;

    // DDRAM geometry
    localparam int unsigned LINE_LEN   = 40;
    localparam int unsigned DDRAM_SIZE = 80;

    // Row base addresses and last valid AC values
    localparam logic [6:0] ROW0_BASE     = 7'h00;
    localparam logic [6:0] ROW1_BASE     = 7'h40;
    localparam logic [6:0] ROW0_LAST     = ROW0_BASE + 7'(LINE_LEN) - 7'd1;
    localparam logic [6:0] ROW1_LAST     = ROW1_BASE + 7'(LINE_LEN) - 7'd1;
    localparam logic [6:0] ONE_LINE_LAST = 7'(DDRAM_SIZE) - 7'd1;

    localparam logic [7:0] SPACE = 8'h20;

    // Instruction opcodes as mask/value pairs, highest priority first
    localparam logic [7:0] OP_DDADDR_MASK = 8'h80, OP_DDADDR_VAL = 8'h80;
    localparam logic [7:0] OP_CGADDR_MASK = 8'hC0, OP_CGADDR_VAL = 8'h40;
    localparam logic [7:0] OP_FUNC_MASK   = 8'hE0, OP_FUNC_VAL   = 8'h20;
    localparam logic [7:0] OP_SHIFT_MASK  = 8'hF0, OP_SHIFT_VAL  = 8'h10;
    localparam logic [7:0] OP_DISP_MASK   = 8'hF8, OP_DISP_VAL   = 8'h08;
    localparam logic [7:0] OP_ENTRY_MASK  = 8'hFC, OP_ENTRY_VAL  = 8'h04;
    localparam logic [7:0] OP_HOME_MASK   = 8'hFE, OP_HOME_VAL   = 8'h02;
    localparam logic [7:0] OP_CLR_MASK    = 8'hFF, OP_CLR_VAL    = 8'h01;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    function automatic logic op_match(input logic [7:0] d, input logic [7:0] mask,
                                      input logic [7:0] val);
        return (d & mask) == val;
    endfunction

    function automatic logic ac_valid(input logic [6:0] a, input logic two_line);
        if (two_line)
            return (a <= ROW0_LAST) || ((a >= ROW1_BASE) && (a <= ROW1_LAST));
        return a <= ONE_LINE_LAST;
    endfunction

    function automatic logic [6:0] ac_inc(input logic [6:0] a, input logic two_line);
        if (two_line) begin
            if (a == ROW0_LAST) return ROW1_BASE;
            if (a == ROW1_LAST) return ROW0_BASE;
            return a + 7'd1;
        end
        if (a == ONE_LINE_LAST) return 7'h00;
        return a + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] a, input logic two_line);
        if (two_line) begin
            if (a == ROW1_BASE) return ROW0_LAST;
            if (a == ROW0_BASE) return ROW1_LAST;
            return a - 7'd1;
        end
        if (a == 7'h00) return ONE_LINE_LAST;
        return a - 7'd1;
    endfunction

    function automatic logic [6:0] ac_next(input logic [6:0] a, input logic inc,
                                           input logic two_line);
        return inc ? ac_inc(a, two_line) : ac_dec(a, two_line);
    endfunction

endpackage

// File: rtl/lcd_responder_if.sv
// LCD parallel bus: controller drives e/rs/rw/data_in, target returns data_out/oe.
interface lcd_responder_if;

    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (
        output lcd_e, lcd_rs, lcd_rw, lcd_data_in,
        input  lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  lcd_e, lcd_rs, lcd_rw, lcd_data_in,
        output lcd_data_out, lcd_data_oe
    );

endinterface

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: one synchronous write port (fill or AC-addressed),
// a combinational bus read port at AC and a registered debug read port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       sysrst,
    input  logic       i_we,
    input  logic       i_fill,
    input  logic [6:0] i_fill_idx,
    input  logic [6:0] i_ac,
    input  logic       i_two_line,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    input  logic [6:0] i_dbg_addr,
    output logic [7:0] o_dbg_data
);

    // Second row 0x40..0x67 lands directly after the first row's 40 cells
    function automatic logic [6:0] ac_to_index(input logic [6:0] a, input logic two_line);
        if (two_line && (a >= ROW1_BASE))
            return a - ROW1_BASE + 7'(LINE_LEN);
        return a;
    endfunction

    logic [7:0] r_mem [DDRAM_SIZE];
    logic [7:0] r_dbg_data;
    logic [6:0] w_rd_idx;
    logic [6:0] w_wr_idx;

    assign w_rd_idx = ac_to_index(i_ac, i_two_line);
    assign w_wr_idx = i_fill ? i_fill_idx : w_rd_idx;
    assign o_rdata  = (w_rd_idx < 7'(DDRAM_SIZE)) ? r_mem[w_rd_idx] : '0;
    assign o_dbg_data = r_dbg_data;

    // Single write port shared by clear-fill and data writes
    always_ff @(posedge clk) begin
        if (i_we && (w_wr_idx < 7'(DDRAM_SIZE)))
            r_mem[w_wr_idx] <= i_wdata;
    end

    // Registered debug read; out-of-range indices read as zero
    always_ff @(posedge clk) begin
        if (sysrst)
            r_dbg_data <= '0;
        else if (i_dbg_addr < 7'(DDRAM_SIZE))
            r_dbg_data <= r_mem[i_dbg_addr];
        else
            r_dbg_data <= '0;
    end

endmodule

// File: rtl/lcd_responder.sv
// HD44780-compatible character-LCD target: synchronises the bus, decodes
// instructions and data cycles, and keeps AC, busy timing and display flags.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 120,
    parameter int unsigned CLEAR_CYCLES = 4920,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              sysrst,
    lcd_responder_if.slave    bus,
    output logic              busy,
    output logic [6:0]        ac,
    output logic              disp_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic              two_line,
    output logic              viol,
    input  logic [6:0]        dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int unsigned CNT_MAX = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

    logic [10:0]      r_sync [SYNC_STAGES];
    logic             r_e_prev;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_fill_idx;
    logic [6:0]       r_ac;
    logic             r_id;
    logic             r_disp_on;
    logic             r_cursor_on;
    logic             r_blink_on;
    logic             r_two_line;
    logic             r_viol;
    logic [7:0]       r_data_out;
    logic             r_oe;

    logic             w_e;
    logic             w_rs;
    logic             w_rw;
    logic [7:0]       w_data;
    logic             w_e_rise;
    logic             w_e_fall;
    logic             w_busy;
    logic             w_fill_active;
    logic             w_data_wr;
    logic             w_ram_we;
    logic [7:0]       w_ram_wdata;
    logic [7:0]       w_rd_data;

    assign w_e      = r_sync[SYNC_STAGES-1][10];
    assign w_rs     = r_sync[SYNC_STAGES-1][9];
    assign w_rw     = r_sync[SYNC_STAGES-1][8];
    assign w_data   = r_sync[SYNC_STAGES-1][7:0];
    assign w_e_rise = w_e & ~r_e_prev;
    assign w_e_fall = ~w_e & r_e_prev;
    assign w_busy   = (r_state != ST_IDLE);

    assign w_fill_active = !sysrst && (r_state == ST_CLEAR) && (r_fill_idx < 7'(DDRAM_SIZE));
    assign w_data_wr     = !sysrst && w_e_fall && !w_rw && w_rs && !w_busy;
    assign w_ram_we      = w_fill_active | w_data_wr;
    assign w_ram_wdata   = w_fill_active ? SPACE : w_data;

    assign busy             = w_busy;
    assign ac               = r_ac;
    assign disp_on          = r_disp_on;
    assign cursor_on        = r_cursor_on;
    assign blink_on         = r_blink_on;
    assign two_line         = r_two_line;
    assign viol             = r_viol;
    assign bus.lcd_data_out = r_data_out;
    assign bus.lcd_data_oe  = r_oe;

    // Bus input synchroniser; all fields travel through the same stages
    always_ff @(posedge clk) begin
        if (sysrst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++)
                r_sync[i] <= '0;
            r_e_prev <= 1'b0;
        end else begin
            r_sync[0] <= {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data_in};
            for (int unsigned i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
            r_e_prev <= w_e;
        end
    end

    // Control FSM, busy timer, instruction decode and read-cycle response
    always_ff @(posedge clk) begin
        if (sysrst) begin
            r_state     <= ST_CLEAR;
            r_cnt       <= CLEAR_LOAD;
            r_fill_idx  <= '0;
            r_ac        <= '0;
            r_id        <= 1'b1;
            r_disp_on   <= 1'b0;
            r_cursor_on <= 1'b0;
            r_blink_on  <= 1'b0;
            r_two_line  <= 1'b0;
            r_viol      <= 1'b0;
            r_data_out  <= '0;
            r_oe        <= 1'b0;
        end else begin
            if (w_fill_active)
                r_fill_idx <= r_fill_idx + 7'd1;

            if (r_state != ST_IDLE) begin
                if (r_cnt == '0)
                    r_state <= ST_IDLE;
                else
                    r_cnt <= r_cnt - 1'b1;
            end

            if (w_e_rise && w_rw) begin
                r_data_out <= w_rs ? w_rd_data : {w_busy, r_ac};
                r_oe       <= 1'b1;
            end

            if (w_e_fall) begin
                r_oe <= 1'b0;
                if (!w_rw) begin
                    if (w_busy) begin
                        r_viol <= 1'b1;
                    end else begin
                        // Default path is EXEC; clear/home override it below
                        r_state <= ST_EXEC;
                        r_cnt   <= BUSY_LOAD;
                        if (w_rs) begin
                            r_ac <= ac_next(r_ac, r_id, r_two_line);
                        end else if (op_match(w_data, OP_DDADDR_MASK, OP_DDADDR_VAL)) begin
                            if (ac_valid(w_data[6:0], r_two_line)) begin
                                r_ac <= w_data[6:0];
                            end else begin
                                r_ac   <= '0;
                                r_viol <= 1'b1;
                            end
                        end else if (op_match(w_data, OP_CGADDR_MASK, OP_CGADDR_VAL)) begin
                            r_ac <= r_ac;
                        end else if (op_match(w_data, OP_FUNC_MASK, OP_FUNC_VAL)) begin
                            r_two_line <= w_data[3];
                            if (!w_data[4])
                                r_viol <= 1'b1;
                            if (!ac_valid(r_ac, w_data[3]))
                                r_ac <= '0;
                        end else if (op_match(w_data, OP_SHIFT_MASK, OP_SHIFT_VAL)) begin
                            if (!w_data[3])
                                r_ac <= ac_next(r_ac, w_data[2], r_two_line);
                        end else if (op_match(w_data, OP_DISP_MASK, OP_DISP_VAL)) begin
                            r_disp_on   <= w_data[2];
                            r_cursor_on <= w_data[1];
                            r_blink_on  <= w_data[0];
                        end else if (op_match(w_data, OP_ENTRY_MASK, OP_ENTRY_VAL)) begin
                            r_id <= w_data[1];
                        end else if (op_match(w_data, OP_HOME_MASK, OP_HOME_VAL)) begin
                            // Home reuses CLEAR timing with the fill already marked done
                            r_state    <= ST_CLEAR;
                            r_cnt      <= CLEAR_LOAD;
                            r_fill_idx <= 7'(DDRAM_SIZE);
                            r_ac       <= '0;
                        end else if (op_match(w_data, OP_CLR_MASK, OP_CLR_VAL)) begin
                            r_state    <= ST_CLEAR;
                            r_cnt      <= CLEAR_LOAD;
                            r_fill_idx <= '0;
                            r_ac       <= '0;
                            r_id       <= 1'b1;
                        end
                    end
                end else if (w_rs) begin
                    if (w_busy)
                        r_viol <= 1'b1;
                    else
                        r_ac <= ac_next(r_ac, r_id, r_two_line);
                end
            end
        end
    end

    lcd_ddram u_ddram (
        .clk        (clk),
        .sysrst     (sysrst),
        .i_we       (w_ram_we),
        .i_fill     (w_fill_active),
        .i_fill_idx (r_fill_idx),
        .i_ac       (r_ac),
        .i_two_line (r_two_line),
        .i_wdata    (w_ram_wdata),
        .o_rdata    (w_rd_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: bus write/read cycles with hand-computed
// expectations, checked through the debug port and status outputs.
module tb_lcd_responder;

    localparam int unsigned BUSY_C  = 24;
    localparam int unsigned CLEAR_C = 100;

    logic       clk;
    logic       sysrst;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, two_line, viol;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_checks;
    int n_fail;

    lcd_responder_if bus ();

    lcd_responder #(
        .BUSY_CYCLES  (BUSY_C),
        .CLEAR_CYCLES (CLEAR_C),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .sysrst    (sysrst),
        .bus       (bus),
        .busy      (busy),
        .ac        (ac),
        .disp_on   (disp_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .two_line  (two_line),
        .viol      (viol),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One bus cycle; returns 4 clocks after e falls so the edge has been acted on
    task automatic bus_write(input logic rs, input logic [7:0] d);
        bus.lcd_rs = rs; bus.lcd_rw = 1'b0; bus.lcd_data_in = d;
        tick(2);
        bus.lcd_e = 1'b1;
        tick(4);
        bus.lcd_e = 1'b0;
        tick(4);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check_val("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        bus_write(rs, d);
        wait_idle();
    endtask

    task automatic bus_read(input logic rs, output logic oe_pre, output logic oe_hi,
                            output logic [7:0] d_hi, output logic oe_post);
        bus.lcd_rs = rs; bus.lcd_rw = 1'b1;
        tick(2);
        oe_pre = bus.lcd_data_oe;
        bus.lcd_e = 1'b1;
        tick(4);
        oe_hi = bus.lcd_data_oe;
        d_hi  = bus.lcd_data_out;
        bus.lcd_e = 1'b0;
        tick(4);
        oe_post = bus.lcd_data_oe;
        bus.lcd_rw = 1'b0;
    endtask

    task automatic rd_dbg(input logic [6:0] idx, output logic [7:0] d);
        dbg_addr = idx;
        @(negedge clk);
        d = dbg_data;
    endtask

    // Counts clocks from reset release until busy drops
    task automatic measure_clear(input string tag);
        int n;
        n = 0;
        sysrst = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (busy === 1'b1 && n < CLEAR_C + 50);
        check_val(tag, n, CLEAR_C);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},  busy, 1'b1);
        check_val({tag, "_ac"},    ac, 7'h00);
        check_val({tag, "_flags"}, {disp_on, cursor_on, blink_on, two_line}, 4'h0);
        check_val({tag, "_viol"},  viol, 1'b0);
        check_val({tag, "_oe"},    bus.lcd_data_oe, 1'b0);
        check_val({tag, "_dout"},  bus.lcd_data_out, 8'h00);
    endtask

    initial begin
        logic [7:0] d;
        logic oe_pre, oe_hi, oe_post;
        logic [7:0] d_hi;

        n_checks = 0;
        n_fail   = 0;
        sysrst   = 1'b1;
        bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data_in = 8'h00;
        dbg_addr = 7'd0;

        // Power-on reset
        tick(3);
        check_reset_outputs("rst");
        check_val("rst_dbg", dbg_data, 8'h00);
        measure_clear("rst_busy_len");
        for (int i = 0; i < 80; i++) begin
            rd_dbg(7'(i), d);
            check_val($sformatf("fill0_%0d", i), d, 8'h20);
        end
        check_val("post_rst_ac", ac, 7'h00);
        check_val("post_rst_flags", {disp_on, cursor_on, blink_on, two_line, viol}, 5'h0);

        // Init sequence and "Hi"
        wr(1'b0, 8'h38);
        wr(1'b0, 8'h0C);
        wr(1'b0, 8'h06);
        wr(1'b1, 8'h48);
        wr(1'b1, 8'h69);
        rd_dbg(7'd0, d); check_val("hi_d0", d, 8'h48);
        rd_dbg(7'd1, d); check_val("hi_d1", d, 8'h69);
        check_val("hi_ac", ac, 7'h02);
        check_val("hi_two_line", two_line, 1'b1);
        check_val("hi_disp", {disp_on, cursor_on, blink_on}, 3'b100);
        check_val("hi_viol", viol, 1'b0);

        // Row wrap 0x27 -> 0x40 and back with decrement
        wr(1'b0, 8'hA7);
        check_val("ac_27", ac, 7'h27);
        wr(1'b1, 8'h41);
        rd_dbg(7'd39, d); check_val("wrap_d39", d, 8'h41);
        check_val("wrap_ac_40", ac, 7'h40);
        wr(1'b0, 8'h04);
        wr(1'b1, 8'h42);
        rd_dbg(7'd40, d); check_val("wrap_d40", d, 8'h42);
        check_val("wrap_ac_27", ac, 7'h27);

        // Write while busy, then status read while busy
        wr(1'b0, 8'h06);
        bus_write(1'b1, 8'h55);
        bus_write(1'b1, 8'h66);
        check_val("busy_viol", viol, 1'b1);
        bus_read(1'b0, oe_pre, oe_hi, d_hi, oe_post);
        check_val("stat_oe_pre", oe_pre, 1'b0);
        check_val("stat_oe_hi", oe_hi, 1'b1);
        check_val("stat_data", d_hi, 8'hC0);
        check_val("stat_oe_post", oe_post, 1'b0);
        wait_idle();
        rd_dbg(7'd39, d); check_val("busy_d39", d, 8'h55);
        rd_dbg(7'd40, d); check_val("busy_d40_unchanged", d, 8'h42);
        check_val("busy_ac", ac, 7'h40);

        // Data read at 0x05
        wr(1'b0, 8'h85);
        wr(1'b1, 8'h35);
        check_val("rd_setup_ac", ac, 7'h06);
        wr(1'b0, 8'h85);
        bus_read(1'b1, oe_pre, oe_hi, d_hi, oe_post);
        check_val("rd_oe_hi", oe_hi, 1'b1);
        check_val("rd_data", d_hi, 8'h35);
        check_val("rd_oe_post", oe_post, 1'b0);
        check_val("rd_ac", ac, 7'h06);
        check_val("rd_busy", busy, 1'b0);

        // Row 2 end wraps to 0x00
        wr(1'b0, 8'hE7);
        wr(1'b1, 8'h79);
        rd_dbg(7'd79, d); check_val("wrap_d79", d, 8'h79);
        check_val("wrap_ac_00", ac, 7'h00);

        // Reset mid-EXEC, then again mid-CLEAR
        bus_write(1'b1, 8'h7A);
        check_val("exec_busy", busy, 1'b1);
        sysrst = 1'b1;
        tick(2);
        check_reset_outputs("rst_exec");
        sysrst = 1'b0;
        tick(40);
        check_val("mid_clear_busy", busy, 1'b1);
        sysrst = 1'b1;
        tick(2);
        check_reset_outputs("rst_clear");
        measure_clear("rst2_busy_len");
        for (int i = 0; i < 80; i++) begin
            rd_dbg(7'(i), d);
            check_val($sformatf("fill2_%0d", i), d, 8'h20);
        end
        check_val("rst2_flags", {disp_on, cursor_on, blink_on, two_line, viol}, 5'h0);

        // 1-line wrap and shift
        wr(1'b0, 8'h30);
        wr(1'b0, 8'hCF);
        check_val("l1_ac_4f", ac, 7'h4F);
        wr(1'b1, 8'h5A);
        rd_dbg(7'd79, d); check_val("l1_d79", d, 8'h5A);
        check_val("l1_wrap_ac", ac, 7'h00);
        wr(1'b0, 8'h10);
        check_val("shift_left_wrap", ac, 7'h4F);
        wr(1'b0, 8'h14);
        check_val("shift_right_wrap", ac, 7'h00);

        // AC invalid after switching to 2-line, then invalid DDRAM address
        wr(1'b0, 8'hB0);
        check_val("l1_ac_30", ac, 7'h30);
        wr(1'b0, 8'h38);
        check_val("toggle_ac_forced", ac, 7'h00);
        check_val("toggle_viol", viol, 1'b0);
        wr(1'b0, 8'hB0);
        check_val("bad_addr_ac", ac, 7'h00);
        check_val("bad_addr_viol", viol, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
